// File: rtl/ppu_reg_ctrl.sv
// ppu_reg_ctrl: CPU-facing PPU register file ($2000-$2007), VRAM port
// sequencer for PPUDATA accesses with renderer-priority arbitration, and
// vblank / NMI request generation.
module ppu_reg_ctrl #(
  parameter int INC_ACROSS = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ppu_reg_cs,
  input  logic [2:0]  ppu_reg_addr,
  input  logic        cpu_rw,
  input  logic [7:0]  cpu_wdata,
  output logic [7:0]  cpu_rdata,
  output logic        rdy,
  input  logic        render_req,
  input  logic [13:0] render_addr,
  output logic [13:0] vram_addr,
  output logic [7:0]  vram_wdata,
  output logic        vram_we,
  input  logic [7:0]  vram_rdata,
  input  logic        vblank_set,
  input  logic        vblank_clr,
  input  logic        spr0_hit,
  input  logic        spr_ovf,
  input  logic [7:0]  oam_rdata,
  output logic [7:0]  oam_addr,
  output logic        oam_we,
  output logic [7:0]  ppu_ctrl,
  output logic [7:0]  ppu_mask,
  output logic [7:0]  scroll_x,
  output logic [7:0]  scroll_y,
  output logic        NMI_enable
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_PEND    = 2'd1;
  localparam logic [1:0] ST_RD_WAIT = 2'd2;

  logic        cs_prev_reg;
  logic [1:0]  state_reg;
  logic [13:0] lat_addr_reg;
  logic        lat_write_reg;
  logic [7:0]  lat_data_reg;
  logic [13:0] v_reg;
  logic        w_reg;
  logic [7:0]  rbuf_reg;
  logic [7:0]  ppu_ctrl_reg;
  logic [7:0]  ppu_mask_reg;
  logic [7:0]  scroll_x_reg;
  logic [7:0]  scroll_y_reg;
  logic [7:0]  oam_addr_reg;
  logic        oam_we_reg;
  logic        vblank_reg;
  logic        nmi_reg;
  logic [7:0]  cpu_rdata_reg;

  logic        access;
  logic        wr_acc;
  logic        rd_acc;
  logic        data_acc;
  logic        port_use;
  logic [13:0] v_inc;

  // Access strobe: first cycle of chip select low; a CPU access to $2007 is
  // only taken when the sequencer is idle, otherwise it is dropped.
  assign access   = cs_prev_reg & ~ppu_reg_cs;
  assign wr_acc   = access & ~cpu_rw;
  assign rd_acc   = access & cpu_rw;
  assign data_acc = access && (ppu_reg_addr == 3'd7) && (state_reg == ST_IDLE);
  assign port_use = (state_reg == ST_PEND) && !render_req;
  assign v_inc    = ppu_ctrl_reg[2] ? 14'(INC_ACROSS) : 14'd1;

  // Renderer always owns the port when it asks; write enable is also masked
  // during reset so an aborted access can never reach VRAM.
  assign vram_addr  = render_req ? render_addr : lat_addr_reg;
  assign vram_wdata = lat_data_reg;
  assign vram_we    = port_use && lat_write_reg && !reset;
  assign rdy        = (state_reg == ST_IDLE);

  assign cpu_rdata  = cpu_rdata_reg;
  assign oam_addr   = oam_addr_reg;
  assign oam_we     = oam_we_reg;
  assign ppu_ctrl   = ppu_ctrl_reg;
  assign ppu_mask   = ppu_mask_reg;
  assign scroll_x   = scroll_x_reg;
  assign scroll_y   = scroll_y_reg;
  assign NMI_enable = nmi_reg;

  // Previous chip-select level for the access edge detect.
  always_ff @(posedge clk) begin
    if (reset) cs_prev_reg <= 1'b1;
    else       cs_prev_reg <= ppu_reg_cs;
  end

  // PPUCTRL / PPUMASK register writes.
  always_ff @(posedge clk) begin
    if (reset) begin
      ppu_ctrl_reg <= 8'h00;
      ppu_mask_reg <= 8'h00;
    end else if (wr_acc) begin
      if (ppu_reg_addr == 3'd0) ppu_ctrl_reg <= cpu_wdata;
      if (ppu_reg_addr == 3'd1) ppu_mask_reg <= cpu_wdata;
    end
  end

  // Shared write toggle plus the scroll registers it steers.
  always_ff @(posedge clk) begin
    if (reset) begin
      w_reg        <= 1'b0;
      scroll_x_reg <= 8'h00;
      scroll_y_reg <= 8'h00;
    end else if (rd_acc && ppu_reg_addr == 3'd2) begin
      w_reg <= 1'b0;
    end else if (wr_acc && (ppu_reg_addr == 3'd5 || ppu_reg_addr == 3'd6)) begin
      w_reg <= ~w_reg;
      if (ppu_reg_addr == 3'd5) begin
        if (!w_reg) scroll_x_reg <= cpu_wdata;
        else        scroll_y_reg <= cpu_wdata;
      end
    end
  end

  // VRAM pointer: loaded through $2006 (takes priority), else advanced on port use.
  always_ff @(posedge clk) begin
    if (reset) begin
      v_reg <= 14'd0;
    end else if (wr_acc && ppu_reg_addr == 3'd6) begin
      if (!w_reg) v_reg[13:8] <= cpu_wdata[5:0];
      else        v_reg[7:0]  <= cpu_wdata;
    end else if (port_use) begin
      v_reg <= v_reg + v_inc;
    end
  end

  // OAM address / write pulse; the address advances after the pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      oam_addr_reg <= 8'h00;
      oam_we_reg   <= 1'b0;
    end else begin
      oam_we_reg <= wr_acc && (ppu_reg_addr == 3'd4);
      if (wr_acc && ppu_reg_addr == 3'd3) oam_addr_reg <= cpu_wdata;
      else if (oam_we_reg)                oam_addr_reg <= oam_addr_reg + 8'd1;
    end
  end

  // vblank flag (set wins over clear) and the registered NMI request.
  always_ff @(posedge clk) begin
    if (reset) begin
      vblank_reg <= 1'b0;
      nmi_reg    <= 1'b0;
    end else begin
      if (vblank_set)                                              vblank_reg <= 1'b1;
      else if (vblank_clr || (rd_acc && ppu_reg_addr == 3'd2))     vblank_reg <= 1'b0;
      nmi_reg <= ppu_ctrl_reg[7] & vblank_reg;
    end
  end

  // Registered CPU read data, held until the next read.
  always_ff @(posedge clk) begin
    if (reset) begin
      cpu_rdata_reg <= 8'h00;
    end else if (rd_acc) begin
      case (ppu_reg_addr)
        3'd2:    cpu_rdata_reg <= {vblank_reg, spr0_hit, spr_ovf, 5'b00000};
        3'd4:    cpu_rdata_reg <= oam_rdata;
        3'd7:    cpu_rdata_reg <= rbuf_reg;
        default: cpu_rdata_reg <= 8'h00;
      endcase
    end
  end

  // PPUDATA sequencer: latch request, wait for a free port, then write or read.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= ST_IDLE;
      lat_addr_reg  <= 14'd0;
      lat_write_reg <= 1'b0;
      lat_data_reg  <= 8'h00;
      rbuf_reg      <= 8'h00;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (data_acc) begin
            lat_addr_reg  <= v_reg;
            lat_write_reg <= ~cpu_rw;
            lat_data_reg  <= cpu_wdata;
            state_reg     <= ST_PEND;
          end
        end
        ST_PEND: begin
          if (!render_req) state_reg <= lat_write_reg ? ST_IDLE : ST_RD_WAIT;
        end
        ST_RD_WAIT: begin
          rbuf_reg  <= vram_rdata;
          state_reg <= ST_IDLE;
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ppu_reg_ctrl.sv
// Directed self-checking bench for ppu_reg_ctrl.
module tb_ppu_reg_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        ppu_reg_cs;
  logic [2:0]  ppu_reg_addr;
  logic        cpu_rw;
  logic [7:0]  cpu_wdata;
  logic [7:0]  cpu_rdata;
  logic        rdy;
  logic        render_req;
  logic [13:0] render_addr;
  logic [13:0] vram_addr;
  logic [7:0]  vram_wdata;
  logic        vram_we;
  logic [7:0]  vram_rdata = 8'h00;
  logic        vblank_set;
  logic        vblank_clr;
  logic        spr0_hit;
  logic        spr_ovf;
  logic [7:0]  oam_rdata;
  logic [7:0]  oam_addr;
  logic        oam_we;
  logic [7:0]  ppu_ctrl;
  logic [7:0]  ppu_mask;
  logic [7:0]  scroll_x;
  logic [7:0]  scroll_y;
  logic        NMI_enable;

  int tests = 0;
  int fails = 0;
  logic [7:0] rd;

  ppu_reg_ctrl #(.INC_ACROSS(32)) dut (
    .clk(clk), .reset(reset), .ppu_reg_cs(ppu_reg_cs), .ppu_reg_addr(ppu_reg_addr),
    .cpu_rw(cpu_rw), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .rdy(rdy),
    .render_req(render_req), .render_addr(render_addr), .vram_addr(vram_addr),
    .vram_wdata(vram_wdata), .vram_we(vram_we), .vram_rdata(vram_rdata),
    .vblank_set(vblank_set), .vblank_clr(vblank_clr), .spr0_hit(spr0_hit),
    .spr_ovf(spr_ovf), .oam_rdata(oam_rdata), .oam_addr(oam_addr), .oam_we(oam_we),
    .ppu_ctrl(ppu_ctrl), .ppu_mask(ppu_mask), .scroll_x(scroll_x), .scroll_y(scroll_y),
    .NMI_enable(NMI_enable)
  );

  always #5 clk = ~clk;

  // Synchronous VRAM stand-in: data is a fixed function of the address.
  always @(posedge clk) vram_rdata <= vram_addr[7:0] ^ 8'hA5;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cpu_write(input logic [2:0] a, input logic [7:0] d);
    tick();
    ppu_reg_cs = 1'b0; ppu_reg_addr = a; cpu_rw = 1'b0; cpu_wdata = d;
    tick();
    ppu_reg_cs = 1'b1; cpu_rw = 1'b1;
    $display("[TB] write $200%0d = %02h", a, d);
  endtask

  task automatic cpu_read(input logic [2:0] a, output logic [7:0] d);
    tick();
    ppu_reg_cs = 1'b0; ppu_reg_addr = a; cpu_rw = 1'b1;
    tick();
    ppu_reg_cs = 1'b1;
    d = cpu_rdata;
    $display("[TB] read  $200%0d -> %02h", a, d);
  endtask

  initial begin
    reset = 1'b1; ppu_reg_cs = 1'b1; ppu_reg_addr = 3'd0; cpu_rw = 1'b1; cpu_wdata = 8'h00;
    render_req = 1'b0; render_addr = 14'd0; vblank_set = 1'b0; vblank_clr = 1'b0;
    spr0_hit = 1'b0; spr_ovf = 1'b0; oam_rdata = 8'h00;
    tick(); tick(); tick();
    reset = 1'b0;
    tick();

    // Reset state
    chk("rst_rdy", rdy, 1);
    chk("rst_we", vram_we, 0);
    chk("rst_oam_we", oam_we, 0);
    chk("rst_rdata", cpu_rdata, 0);
    chk("rst_nmi", NMI_enable, 0);
    chk("rst_ctrl", ppu_ctrl, 0);
    chk("rst_vaddr", vram_addr, 0);

    // $2006 = 21, 08 then $2007 write
    cpu_write(3'd6, 8'h21);
    cpu_write(3'd6, 8'h08);
    cpu_write(3'd7, 8'h5A);
    chk("wr_we", vram_we, 1);
    chk("wr_addr", vram_addr, 16'h2108);
    chk("wr_data", vram_wdata, 8'h5A);
    chk("wr_rdy_busy", rdy, 0);
    tick();
    chk("wr_we_off", vram_we, 0);
    chk("wr_rdy_back", rdy, 1);
    cpu_read(3'd7, rd);
    chk("rd_v_inc1", vram_addr, 16'h2109);
    chk("rd_old_rbuf", rd, 8'h00);
    tick(); tick();
    chk("rd_rdy_back", rdy, 1);

    // Increment-across with 14-bit wrap
    cpu_write(3'd0, 8'h04);
    chk("ctrl_04", ppu_ctrl, 8'h04);
    cpu_write(3'd6, 8'h3F);
    cpu_write(3'd6, 8'hF0);
    cpu_read(3'd7, rd);
    chk("rd1_addr", vram_addr, 16'h3FF0);
    chk("rd1_data", rd, 8'hAC);
    tick(); tick();
    cpu_read(3'd7, rd);
    chk("rd2_addr", vram_addr, 16'h0010);
    chk("rd2_data", rd, 8'h55);
    tick(); tick();
    cpu_read(3'd7, rd);
    chk("rd3_addr", vram_addr, 16'h0030);
    chk("rd3_data", rd, 8'hB5);
    tick(); tick();

    // Renderer contention during a $2007 write
    render_req = 1'b1; render_addr = 14'h1234;
    cpu_write(3'd7, 8'h77);
    for (int i = 0; i < 5; i++) begin
      chk("stall_rdy", rdy, 0);
      chk("stall_we", vram_we, 0);
      chk("stall_addr", vram_addr, 16'h1234);
      tick();
    end
    cpu_read(3'd7, rd);
    chk("drop_rdata", rd, 8'h95);
    chk("drop_rdy", rdy, 0);
    tick();
    chk("stall_we_late", vram_we, 0);
    render_req = 1'b0;
    #1;
    chk("release_we", vram_we, 1);
    chk("release_addr", vram_addr, 16'h0050);
    chk("release_data", vram_wdata, 8'h77);
    tick();
    chk("release_rdy", rdy, 1);
    chk("release_we_off", vram_we, 0);
    tick();
    chk("no_extra_we", vram_we, 0);

    // vblank / NMI
    cpu_write(3'd0, 8'h80);
    vblank_set = 1'b1;
    tick();
    vblank_set = 1'b0;
    chk("nmi_lag", NMI_enable, 0);
    tick();
    chk("nmi_on", NMI_enable, 1);
    cpu_read(3'd2, rd);
    chk("status_80", rd, 8'h80);
    tick();
    chk("nmi_off", NMI_enable, 0);
    tick();
    ppu_reg_cs = 1'b0; ppu_reg_addr = 3'd2; cpu_rw = 1'b1; vblank_set = 1'b1;
    tick();
    ppu_reg_cs = 1'b1; vblank_set = 1'b0;
    $display("[TB] read  $2002 with vblank_set -> %02h", cpu_rdata);
    chk("status_coincident", cpu_rdata, 8'h00);
    tick();
    chk("nmi_after_coinc", NMI_enable, 1);
    cpu_read(3'd2, rd);
    chk("status_kept", rd, 8'h80);

    // Scroll write toggle cleared by status read
    cpu_write(3'd5, 8'h11);
    cpu_write(3'd5, 8'h22);
    chk("scroll_y_22", scroll_y, 8'h22);
    cpu_write(3'd5, 8'h66);
    cpu_read(3'd2, rd);
    cpu_write(3'd5, 8'h33);
    chk("scroll_x_33", scroll_x, 8'h33);
    chk("scroll_y_kept", scroll_y, 8'h22);

    // PPUMASK and OAM
    cpu_write(3'd1, 8'h1E);
    chk("mask", ppu_mask, 8'h1E);
    cpu_write(3'd3, 8'h10);
    chk("oam_addr_10", oam_addr, 8'h10);
    cpu_write(3'd4, 8'hAB);
    chk("oam_we_on", oam_we, 1);
    chk("oam_addr_hold", oam_addr, 8'h10);
    tick();
    chk("oam_we_off", oam_we, 0);
    chk("oam_addr_inc", oam_addr, 8'h11);
    cpu_write(3'd3, 8'hFF);
    cpu_write(3'd4, 8'h00);
    tick();
    chk("oam_addr_wrap", oam_addr, 8'h00);
    cpu_read(3'd0, rd);
    chk("rd_ctrl_zero", rd, 8'h00);
    oam_rdata = 8'h3C;
    cpu_read(3'd4, rd);
    chk("oam_rdata", rd, 8'h3C);

    // Reset in the middle of a pending write
    render_req = 1'b1; render_addr = 14'h0ABC;
    cpu_write(3'd7, 8'h99);
    chk("pend_rdy", rdy, 0);
    reset = 1'b1; render_req = 1'b0;
    #1;
    chk("rst_mid_we", vram_we, 0);
    tick();
    reset = 1'b0;
    #1;
    chk("rst_mid_rdy", rdy, 1);
    chk("rst_mid_we2", vram_we, 0);
    chk("rst_mid_ctrl", ppu_ctrl, 0);
    chk("rst_mid_mask", ppu_mask, 0);
    chk("rst_mid_sx", scroll_x, 0);
    chk("rst_mid_sy", scroll_y, 0);
    chk("rst_mid_oam", oam_addr, 0);
    chk("rst_mid_rdata", cpu_rdata, 0);
    chk("rst_mid_nmi", NMI_enable, 0);
    chk("rst_mid_vaddr", vram_addr, 0);
    tick();
    chk("rst_mid_we3", vram_we, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ppu_reg_ctrl.md
# ppu_reg_ctrl

CPU-facing register controller for the PPU. It decodes the eight PPU registers ($2000–$2007) and holds PPUCTRL, PPUMASK, scroll, OAM address and the VRAM address pointer. It sequences CPU PPUDATA reads and writes into the shared VRAM port and arbitrates that port against the background renderer, which always has priority. It sits between the CPU bus and the rest of `ppu_toplevel`, and generates the NMI request.

## Interface
Parameters:
- `INC_ACROSS`, default 32: VRAM pointer increment when PPUCTRL[2]=1.

Ports:
- `clk` in 1: system clock.
- `reset` in 1: synchronous, active-high.
- `ppu_reg_cs` in 1: chip select, active-low.
- `ppu_reg_addr` in 3: register index 0–7.
- `cpu_rw` in 1: 1 = read, 0 = write.
- `cpu_wdata` in 8: CPU write data.
- `cpu_rdata` out 8: registered CPU read data.
- `rdy` out 1: 0 while a PPUDATA VRAM access is pending.
- `render_req` in 1: renderer wants the VRAM port this cycle.
- `render_addr` in 14: renderer fetch address.
- `vram_addr` out 14: VRAM address (combinational mux).
- `vram_wdata` out 8: VRAM write data.
- `vram_we` out 1: VRAM write enable.
- `vram_rdata` in 8: synchronous VRAM read data, valid 1 cycle after the address is presented.
- `vblank_set` in 1: 1-cycle pulse from the timing generator.
- `vblank_clr` in 1: 1-cycle pulse from the timing generator.
- `spr0_hit` in 1, `spr_ovf` in 1: status flags, level inputs.
- `oam_rdata` in 8: OAM read data.
- `oam_addr` out 8: OAM address.
- `oam_we` out 1: OAM write enable.
- `ppu_ctrl` out 8, `ppu_mask` out 8, `scroll_x` out 8, `scroll_y` out 8: register contents.
- `NMI_enable` out 1: registered NMI request, equal to `ppu_ctrl[7] & vblank`.

## Operation
**Access strobe**
- An access is the first cycle in which `ppu_reg_cs` is low; a registered edge detect generates it.
- Holding `ppu_reg_cs` low produces no further accesses.

**Register writes**
- 0: write PPUCTRL.
- 1: write PPUMASK.
- 2: ignored.
- 3: write `oam_addr`.
- 4: `oam_we` pulses for 1 cycle, then `oam_addr`+1 (wraps mod 256).
- 5: write toggle `w`=0 writes `scroll_x`; `w`=1 writes `scroll_y`. `w` flips.
- 6: `w`=0 writes `v[13:8]` = data[5:0]; `w`=1 writes `v[7:0]`. `w` flips.
- 7: start a VRAM write of `cpu_wdata` at `v`.

**Register reads**
- 2: returns {vblank, spr0_hit, spr_ovf, 5'b0}. Clears `vblank` and `w`.
- 4: returns `oam_rdata`.
- 7: returns the read buffer `rbuf` (pre-access value) and starts a VRAM read at `v`. The fetched byte refills `rbuf`.
- 0, 1, 3, 5, 6: return 0.

**VRAM FSM (IDLE, PEND, RD_WAIT)**
- IDLE: a $2007 access latches addr=`v`, the direction and data, sets `rdy`=0, and goes to PEND.
- PEND with `render_req`=1: stall; the renderer owns the port.
- PEND with `render_req`=0, write: drive the port, `vram_we`=1 for 1 cycle, go to IDLE.
- PEND with `render_req`=0, read: drive the address, go to RD_WAIT.
- RD_WAIT: `rbuf`<=`vram_rdata`, go to IDLE. The renderer is still granted in RD_WAIT; `vram_rdata` is captured regardless.
- `v` increments by 1, or `INC_ACROSS` if PPUCTRL[2]=1, in the cycle the port is used. `v` wraps mod 2^14.
- `rdy`=1 on return to IDLE.
- A $2007 access while `rdy`=0 is dropped: no state change, read returns `rbuf`. Other registers are always serviced.
- A $2006 write while `rdy`=0 updates `v`; the in-flight access keeps its latched address.

**Port mux**
- `vram_addr` = `render_addr` when `render_req`=1, else the latched CPU address.
- `vram_we` is never asserted while `render_req`=1.

**vblank**
- Set by `vblank_set`, cleared by `vblank_clr` or a status read.
- Set wins over clear in the same cycle; the status read then returns the pre-cycle bit.

## Timing
- Reset values: all registers, `v`, `w`, `rbuf`, `oam_addr` = 0; `vblank`=0; FSM=IDLE; `rdy`=1; `vram_we`=0; `oam_we`=0; `cpu_rdata`=0; `NMI_enable`=0.
- `cpu_rdata` is valid in the cycle after the access strobe and holds until the next read.
- Register writes are visible on outputs 1 cycle after the strobe.
- Uncontended $2007 write: `vram_we` asserts 1 cycle after the strobe; `rdy` returns 1 after 2 cycles.
- Uncontended $2007 read: `rbuf` updated 3 cycles after the strobe.
- `NMI_enable` lags `vblank` or `ppu_ctrl[7]` by 1 cycle.
- Reset mid-access aborts it: FSM=IDLE, no `vram_we`.

## Test plan
- Write $2006=0x21, then $2006=0x08, then $2007=0x5A with `render_req`=0 -> `vram_we` pulses with `vram_addr`=0x2108 and `vram_wdata`=0x5A; `v`=0x2109.
- PPUCTRL=0x04, $2006 = 0x3F then 0xF0, then read $2007 twice -> `v` goes 0x3FF0 -> 0x0010 -> 0x0030 (wraps mod 2^14); the first read returns the old `rbuf`.
- Hold `render_req`=1 for 10 cycles during a $2007 write -> `rdy`=0 throughout, `vram_addr`=`render_addr`, no `vram_we`; the write completes 1 cycle after `render_req` falls.
- Pulse `vblank_set` with PPUCTRL[7]=1 -> `NMI_enable`=1; read $2002 -> 0x80 and `NMI_enable`=0 next cycle. A status read coincident with `vblank_set` returns 0x00 and vblank stays set.
- Write $2005 once, read $2002, write $2005=0x33 -> `scroll_x`=0x33, `scroll_y` unchanged.
- Assert reset mid-PEND -> all outputs return to reset values and no VRAM write occurs.
